// File: rtl/fa16b_rev_pkg.sv
// -----------------------------------------------------------------------------
// fa16b_rev_pkg
// Shared definitions for the reversible 16-bit dual-rail adder sequencer:
//   - WIDTH        : addend / sum width
//   - SETTLE_MIN/MAX: legal range of the per-phase settle time
//   - CNT_W        : width of the phase down-counter (holds SETTLE_MAX-1)
//   - rev_state_t  : sequencer phases
//   - rail_pair_bad: flags a dual-rail pair that is not a valid code word
// -----------------------------------------------------------------------------
package fa16b_rev_pkg;

   localparam int WIDTH      = 16;
   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 255;
   localparam int CNT_W      = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FWD   = 3'd1,
      BWD   = 3'd2,
      REL_F = 3'd3,
      REL_B = 3'd4
   } rev_state_t;

   // A settled dual-rail bit must have exactly one rail high; equal rails
   // (null or both-high) at the sample point indicate a broken adder output.
   function automatic logic rail_pair_bad(input logic rail, input logic rail_not);
      return rail == rail_not;
   endfunction

endpackage

// File: rtl/fa16b_rev_seq_timer.sv
// -----------------------------------------------------------------------------
// rev_phase_timer
// Down-counter that times each sequencer phase.
//   clk      : clock
//   rst      : synchronous active-high reset (counter -> 0)
//   load     : load load_val this edge (takes precedence over counting)
//   load_val : value loaded; the phase lasts load_val+1 cycles
//   done     : counter is at zero (last cycle of the current phase)
// -----------------------------------------------------------------------------
module rev_phase_timer
   import fa16b_rev_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign done = (r_cnt == '0);

endmodule

// File: rtl/fa16b_rev_seq.sv
// -----------------------------------------------------------------------------
// fa16b_rev_seq
// Sequencer for a reversible dual-rail 16-bit adder. A request is latched,
// then the adder inputs are walked through four phases of SETTLE_CYC cycles:
//   FWD   : forward rails (a, b, cin) driven; sum sampled on the last cycle
//   BWD   : backward (uncompute) rails driven in addition
//   REL_F : forward a/cin rails released to null, b and backward rails kept
//   REL_B : everything released to null, then back to IDLE
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake; req_a, req_b, req_cin payload
//   a_f/a_not_f, b/b_not     : forward dual-rail addend drive
//   c0_f/c0_f_not            : forward carry-in rails
//   a_b/a_not_b, c0_b/c0_not_b : backward (uncompute) rails
//   s/s_not, c15/c15_not     : dual-rail sum and carry-out from the adder
//   rsp_valid/rsp_ready      : response handshake
//   rsp_sum, rsp_cout, rsp_err : response payload (err = invalid rail pair)
// -----------------------------------------------------------------------------
module fa16b_rev_seq
   import fa16b_rev_pkg::*;
#(
   parameter int SETTLE_CYC = 2
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_cin,
   output logic [WIDTH-1:0] a_f,
   output logic [WIDTH-1:0] a_not_f,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] b_not,
   output logic             c0_f,
   output logic             c0_f_not,
   output logic [WIDTH-1:0] a_b,
   output logic [WIDTH-1:0] a_not_b,
   output logic             c0_b,
   output logic             c0_not_b,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] s_not,
   input  logic             c15,
   input  logic             c15_not,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_err
);

   // Timer counts load value down to zero, so load SETTLE_CYC-1.
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

   rev_state_t       r_state;
   rev_state_t       w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cin;

   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_sum;
   logic             r_rsp_cout;
   logic             r_rsp_err;

   logic             w_accept;
   logic             w_done;
   logic             w_load;
   logic             w_sample;
   logic [WIDTH:0]   w_pair_bad;
   logic             w_rail_err;
   logic             w_fwd_on;
   logic             w_b_on;
   logic             w_bwd_on;

   assign req_ready = (r_state == IDLE) && !r_rsp_valid;
   assign w_accept  = req_valid && req_ready;
   assign w_sample  = (r_state == FWD) && w_done;

   // Reload the timer on every entry into a timed (non-IDLE) phase.
   assign w_load = (w_state_next != r_state) && (w_state_next != IDLE);

   rev_phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (LOAD_VAL),
      .done     (w_done)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = FWD;
         FWD:     if (w_done)   w_state_next = BWD;
         BWD:     if (w_done)   w_state_next = REL_F;
         REL_F:   if (w_done)   w_state_next = REL_B;
         REL_B:   if (w_done)   w_state_next = IDLE;
         default:               w_state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Each rail pair is gated by a single enable, so a pair is either the
   // code word of its data bit or null; both-high can never be produced.
   always_comb begin
      w_fwd_on = 1'b0;
      w_b_on   = 1'b0;
      w_bwd_on = 1'b0;
      case (r_state)
         FWD:   begin w_fwd_on = 1'b1; w_b_on = 1'b1; end
         BWD:   begin w_fwd_on = 1'b1; w_b_on = 1'b1; w_bwd_on = 1'b1; end
         REL_F: begin w_b_on = 1'b1; w_bwd_on = 1'b1; end
         default: ;
      endcase

      a_f      =  r_a & {WIDTH{w_fwd_on}};
      a_not_f  = ~r_a & {WIDTH{w_fwd_on}};
      c0_f     =  r_cin & w_fwd_on;
      c0_f_not = ~r_cin & w_fwd_on;
      b        =  r_b & {WIDTH{w_b_on}};
      b_not    = ~r_b & {WIDTH{w_b_on}};
      a_b      =  r_a & {WIDTH{w_bwd_on}};
      a_not_b  = ~r_a & {WIDTH{w_bwd_on}};
      c0_b     =  r_cin & w_bwd_on;
      c0_not_b = ~r_cin & w_bwd_on;
   end

   // ---------------- Rail validity of the adder result ----------------
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sum_chk
         assign w_pair_bad[gi] = rail_pair_bad(s[gi], s_not[gi]);
      end
   endgenerate
   assign w_pair_bad[WIDTH] = rail_pair_bad(c15, c15_not);
   assign w_rail_err        = |w_pair_bad;

   // ---------------- Operand latch (only at accept) ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cin <= 1'b0;
      end else if (w_accept) begin
         r_a   <= req_a;
         r_b   <= req_b;
         r_cin <= req_cin;
      end
   end

   // ---------------- Response register ----------------
   // A new response can only be sampled when the previous one was already
   // taken (requests are accepted only with rsp_valid low), so the set and
   // clear below never compete for the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_sum   <= '0;
         r_rsp_cout  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else if (w_sample) begin
         r_rsp_valid <= 1'b1;
         r_rsp_sum   <= s;
         r_rsp_cout  <= c15;
         r_rsp_err   <= w_rail_err;
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_sum   = r_rsp_sum;
   assign rsp_cout  = r_rsp_cout;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_fa16b_rev_seq.sv
// -----------------------------------------------------------------------------
// tb_fa16b_rev_seq
// Directed bench for fa16b_rev_seq with an ideal dual-rail adder model.
// -----------------------------------------------------------------------------
module tb_fa16b_rev_seq;

   localparam int S = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        req_cin;
   logic [15:0] a_f, a_not_f, b, b_not, a_b, a_not_b;
   logic        c0_f, c0_f_not, c0_b, c0_not_b;
   logic [15:0] s, s_not;
   logic        c15, c15_not;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_sum;
   logic        rsp_cout;
   logic        rsp_err;

   logic        force_err;
   logic [16:0] m_sum;
   logic        m_ok;
   logic [99:0] rails;
   logic        both1;

   int n_assert = 0;
   int n_fail   = 0;

   fa16b_rev_seq #(.SETTLE_CYC(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .a_f       (a_f),
      .a_not_f   (a_not_f),
      .b         (b),
      .b_not     (b_not),
      .c0_f      (c0_f),
      .c0_f_not  (c0_f_not),
      .a_b       (a_b),
      .a_not_b   (a_not_b),
      .c0_b      (c0_b),
      .c0_not_b  (c0_not_b),
      .s         (s),
      .s_not     (s_not),
      .c15       (c15),
      .c15_not   (c15_not),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ideal dual-rail adder: produces a code word only once all forward
   // inputs are valid code words, otherwise null on every output pair.
   always_comb begin
      m_ok    = (&(a_f ^ a_not_f)) && (&(b ^ b_not)) && (c0_f ^ c0_f_not);
      m_sum   = {1'b0, a_f} + {1'b0, b} + {16'h0, c0_f};
      s       = 16'h0;
      s_not   = 16'h0;
      c15     = 1'b0;
      c15_not = 1'b0;
      if (m_ok) begin
         s       = m_sum[15:0];
         s_not   = ~m_sum[15:0];
         c15     = m_sum[16];
         c15_not = ~m_sum[16];
      end
      if (force_err) begin
         s[3]     = 1'b0;
         s_not[3] = 1'b0;
      end
   end

   assign rails = {a_f, a_not_f, b, b_not, c0_f, c0_f_not, a_b, a_not_b, c0_b, c0_not_b};
   assign both1 = (|(a_f & a_not_f)) | (|(b & b_not)) | (c0_f & c0_f_not)
                | (|(a_b & a_not_b)) | (c0_b & c0_not_b);

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Expected rail drive for a phase: 0 FWD, 1 BWD, 2 REL_F, 3 REL_B, 4 IDLE.
   function automatic logic [99:0] exp_rails(input int ph, input logic [15:0] a,
                                             input logic [15:0] bb, input logic cin);
      logic fw, bo, bw;
      fw = (ph == 0) || (ph == 1);
      bo = (ph <= 2);
      bw = (ph == 1) || (ph == 2);
      return {fw ? a : 16'h0, fw ? ~a : 16'h0, bo ? bb : 16'h0, bo ? ~bb : 16'h0,
              fw & cin, fw & ~cin, bw ? a : 16'h0, bw ? ~a : 16'h0, bw & cin, bw & ~cin};
   endfunction

   // Issue one operation (rsp_ready held low) and trace it cycle by cycle
   // from the accept edge (edge 0) until IDLE is re-entered after edge 4*S.
   task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] bb,
                        input logic cin, input logic [15:0] es, input logic ec, input logic ee);
      int guard;
      int ph;
      guard     = 0;
      req_a     = a;
      req_b     = bb;
      req_cin   = cin;
      req_valid = 1'b1;
      while (!req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         chk({name, "_accept_timeout"}, 128'(0), 128'(1));
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      // Request inputs must be ignored after accept; drive garbage.
      req_valid = 1'b0;
      req_a     = ~a;
      req_b     = ~bb;
      req_cin   = ~cin;
      for (int e = 0; e <= 4 * S; e++) begin
         ph = e / S;
         chk({name, "_rails"}, 128'(rails), 128'(exp_rails(ph, a, bb, cin)));
         chk({name, "_both1"}, 128'(both1), 128'(0));
         chk({name, "_req_ready"}, 128'(req_ready), 128'(0));
         chk({name, "_rsp_valid"}, 128'(rsp_valid), 128'(e >= S));
         if (e >= S)
            chk({name, "_payload"}, 128'({rsp_sum, rsp_cout, rsp_err}), 128'({es, ec, ee}));
         if (e < 4 * S) @(negedge clk);
      end
      $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d", name, a, bb, cin,
               rsp_sum, rsp_cout, rsp_err);
   endtask

   task automatic accept_rsp(input string name);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({name, "_rsp_cleared"}, 128'(rsp_valid), 128'(0));
      chk({name, "_ready_after"}, 128'(req_ready), 128'(1));
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = 16'h0;
      req_b     = 16'h0;
      req_cin   = 1'b0;
      rsp_ready = 1'b0;
      force_err = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_rails", 128'(rails), 128'(0));
      chk("reset_rsp", 128'({rsp_valid, rsp_sum, rsp_cout, rsp_err}), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", 128'(req_ready), 128'(1));
      $display("reset released");

      // Basic add
      do_op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      accept_rsp("add1");

      // Full carry ripple to carry-out
      do_op("carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Back-pressure: response held, second request waits
      req_a     = 16'h0F0F;
      req_b     = 16'h00F1;
      req_cin   = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_req_ready", 128'(req_ready), 128'(0));
         chk("bp_rsp_hold", 128'({rsp_valid, rsp_sum, rsp_cout, rsp_err}), 128'({1'b1, 16'h0000, 1'b1, 1'b0}));
         chk("bp_rails_idle", 128'(rails), 128'(0));
      end
      $display("backpressure held 20 cycles");
      accept_rsp("carry");
      do_op("second", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);
      accept_rsp("second");

      // Broken adder output on bit 3
      force_err = 1'b1;
      do_op("err", 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
      force_err = 1'b0;
      accept_rsp("err");

      // Reset during BWD
      req_a     = 16'h00FF;
      req_b     = 16'h0001;
      req_cin   = 1'b0;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (S) @(negedge clk);
      chk("mid_bwd_rails", 128'(rails), 128'(exp_rails(1, 16'h00FF, 16'h0001, 1'b0)));
      chk("mid_rsp", 128'({rsp_valid, rsp_sum}), 128'({1'b1, 16'h0100}));
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rails", 128'(rails), 128'(0));
      chk("mid_rst_rsp", 128'({rsp_valid, rsp_sum, rsp_cout, rsp_err}), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", 128'(req_ready), 128'(1));
      $display("reset during BWD");
      do_op("post_rst", 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0);
      accept_rsp("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fa16b_rev_seq.md
FA16B_REV_SEQ -- requirements
Module: fa16b_rev_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, range 1..255: cycles each rail phase is held before the next phase.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: operation request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have ports req_a and req_b, input, 16 bits each: addends.
REQ-008 SHALL have port req_cin, input, 1 bit: carry-in.
REQ-009 SHALL have ports a_f/a_not_f and b/b_not, output, 16 bits each: forward dual-rail addend drive to the adder.
REQ-010 SHALL have ports c0_f/c0_f_not, output, 1 bit each: forward carry rails.
REQ-011 SHALL have ports a_b/a_not_b, output, 16 bits each, and c0_b/c0_not_b, output, 1 bit each: backward (uncompute) rails.
REQ-012 SHALL have ports s/s_not, input, 16 bits each, and c15/c15_not, input, 1 bit each: dual-rail sum and carry-out from the adder.
REQ-013 SHALL have port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: response handshake.
REQ-014 SHALL have ports rsp_sum (output, 16 bits), rsp_cout (output, 1 bit) and rsp_err (output, 1 bit): response payload.

Function
REQ-015 SHALL have FSM states IDLE, FWD, BWD, REL_F and REL_B; each non-IDLE state lasts exactly SETTLE_CYC cycles, timed by a down-counter.
REQ-016 SHALL drive req_ready = (state==IDLE) && !rsp_valid; a request is accepted when req_valid && req_ready.
REQ-017 SHALL on accept register a, b and cin and enter FWD, with outputs a_f=a, a_not_f=~a, b=b, b_not=~b, c0_f=cin, c0_f_not=~cin visible from the next cycle.
REQ-018 SHALL at the last FWD cycle sample s, c15, s_not and c15_not: rsp_sum<=s, rsp_cout<=c15, rsp_err<=1 if any of the 17 bit pairs has rail==rail_not; set rsp_valid and enter BWD.
REQ-019 SHALL in BWD keep the forward rails and additionally drive a_b=a, a_not_b=~a, c0_b=cin, c0_not_b=~cin.
REQ-020 SHALL in REL_F drive a_f, a_not_f, c0_f and c0_f_not to 0 while keeping b and the backward rails.
REQ-021 SHALL in REL_B drive the backward rails, b and b_not to 0, then return to IDLE.
REQ-022 SHALL hold every rail pair at the null value (both 0) in IDLE, and SHALL never drive any rail pair to both 1.
REQ-023 SHALL hold rsp_valid and the rsp_* payload stable until rsp_ready; rsp_valid clears on the accepting edge, and acceptance may occur in any state.
REQ-024 SHALL set latency, with accept at edge 0, to: rsp_valid high after edge SETTLE_CYC; IDLE re-entered after edge 4*SETTLE_CYC.
REQ-025 SHALL ignore req_valid outside IDLE; all request inputs are sampled only at accept.

Reset
REQ-026 SHALL on rst, including mid-operation, go to IDLE at the next edge with all rails 0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_err=0, counter=0; req_ready=1 in the cycle after reset deasserts.

Structure
REQ-027 SHALL place the FSM state enum, WIDTH=16 and the SETTLE_CYC bounds in shared package fa16b_rev_pkg.
REQ-028 SHALL implement the settle down-counter as sub-module rev_phase_timer (inputs load and load value; output done).

Verification
REQ-029 SHALL cover, with SETTLE_CYC=2 and an ideal dual-rail adder model: a=0x1234, b=0x4321, cin=0 -> rsp_sum=0x5555, rsp_cout=0, rsp_err=0, rsp_valid after edge 2, IDLE after edge 8.
REQ-030 SHALL cover a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, rsp_cout=1; rail trace matches the FWD/BWD/REL_F/REL_B sequence, with no both-1 pair in any cycle.
REQ-031 SHALL cover rsp_ready held low for 20 cycles with a second req_valid held high -> first response stable, req_ready=0 until the response is accepted, then the second request is accepted.
REQ-032 SHALL cover the model forcing s[3]=s_not[3]=0 -> rsp_err=1 and teardown completes normally.
REQ-033 SHALL cover rst asserted during BWD -> all rails 0 and rsp_valid=0 at the next edge, then a new operation a=0x0001, b=0x0001, cin=1 -> rsp_sum=0x0003.
